// File: rtl/ysyx_24120013_core_sequencer.sv
// Multi-cycle core control FSM: sequences fetch, decode/execute, optional data-memory
// access and write-back, with per-handshake timeout and sticky halt/error states.
module ysyx_24120013_core_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ifu_req_valid,
    input  logic                 ifu_req_ready,
    input  logic                 ifu_rsp_valid,
    output logic                 inst_latch_en,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_is_ebreak,
    input  logic                 dec_illegal,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    input  logic                 lsu_rsp_valid,
    output logic                 rf_wen,
    output logic                 pc_update,
    output logic                 halt,
    output logic                 err,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_IW   = 3'd1,
        S_EX   = 3'd2,
        S_MR   = 3'd3,
        S_MW   = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    // Counter only ever needs to reach TIMEOUT-1 before the FSM leaves the state.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t               state_reg, state_next;
    logic [WAIT_W-1:0]    wait_reg, wait_next;
    logic                 store_reg, store_next;
    logic [CNT_WIDTH-1:0] retire_reg, retire_next;

    logic awaited;
    logic waiting;
    logic timed_out;

    // The one handshake signal the current state cares about; all others are ignored.
    always_comb begin
        awaited = 1'b0;
        case (state_reg)
            S_IF:    awaited = ifu_req_ready;
            S_IW:    awaited = ifu_rsp_valid;
            S_MR:    awaited = lsu_req_ready;
            S_MW:    awaited = lsu_rsp_valid;
            default: awaited = 1'b0;
        endcase
    end

    always_comb begin
        waiting = 1'b0;
        if (state_reg == S_IF || state_reg == S_IW || state_reg == S_MR || state_reg == S_MW) begin
            waiting = !awaited;
        end
        // Fires on the TIMEOUT-th idle cycle; an arriving handshake suppresses it.
        timed_out = (TIMEOUT != 0) && waiting && ((32'(wait_reg) + 32'd1) >= 32'(TIMEOUT));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IF;
            wait_reg   <= '0;
            store_reg  <= 1'b0;
            retire_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wait_reg   <= wait_next;
            store_reg  <= store_next;
            retire_reg <= retire_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        store_next  = store_reg;
        retire_next = retire_reg;
        case (state_reg)
            S_IF: begin
                if (ifu_req_ready)  state_next = S_IW;
                else if (timed_out) state_next = S_ERR;
            end
            S_IW: begin
                if (ifu_rsp_valid)  state_next = S_EX;
                else if (timed_out) state_next = S_ERR;
            end
            S_EX: begin
                store_next = dec_is_store;
                if (dec_illegal || (dec_is_load && dec_is_store)) state_next = S_ERR;
                else if (dec_is_ebreak)                           state_next = S_HALT;
                else if (dec_is_load || dec_is_store)             state_next = S_MR;
                else                                              state_next = S_WB;
            end
            S_MR: begin
                if (lsu_req_ready)  state_next = S_MW;
                else if (timed_out) state_next = S_ERR;
            end
            S_MW: begin
                if (lsu_rsp_valid)  state_next = S_WB;
                else if (timed_out) state_next = S_ERR;
            end
            S_WB: begin
                retire_next = retire_reg + 1'b1;
                state_next  = S_IF;
            end
            S_HALT:  state_next = S_HALT;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase

        if (state_next != state_reg) wait_next = '0;
        else if (waiting)            wait_next = wait_reg + 1'b1;
        else                         wait_next = wait_reg;
    end

    // Outputs: Moore decode of the state register, except the same-cycle latch strobe.
    // Everything is forced low while reset is held.
    always_comb begin
        ifu_req_valid = 1'b0;
        inst_latch_en = 1'b0;
        lsu_req_valid = 1'b0;
        rf_wen        = 1'b0;
        pc_update     = 1'b0;
        halt          = 1'b0;
        err           = 1'b0;
        state_o       = 3'd0;
        retire_cnt    = '0;
        if (rst) begin
            state_o    = state_reg;
            retire_cnt = retire_reg;
            case (state_reg)
                S_IF:   ifu_req_valid = 1'b1;
                S_IW:   inst_latch_en = ifu_rsp_valid;
                S_MR:   lsu_req_valid = 1'b1;
                S_WB: begin
                    pc_update = 1'b1;
                    rf_wen    = !store_reg;
                end
                S_HALT: halt = 1'b1;
                S_ERR:  err  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
